ir_sensor_conditioner: RTL and testbench

IR_SENSOR_CONDITIONER -- requirements
Module: ir_sensor_conditioner

---
 rtl/ir_cond_pkg.sv | 33 +++
 rtl/ir_debounce.sv | 54 +++++
 rtl/ir_sensor_conditioner.sv | 129 ++++++++++++
 tb/tb_ir_sensor_conditioner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ir_cond_pkg
// Brief    : Shared types, encodings and defaults for the IR sensor conditioner
// Revision : 1.0 - initial release
// ============================================================================
package ir_cond_pkg;

    localparam int c_DEBOUNCE_CYCLES_DEFAULT = 1000;
    localparam int c_LOST_TIMEOUT_DEFAULT    = 50000;

    typedef enum logic [1:0] {
        ST_ON_LINE = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_LOST    = 2'd2
    } state_t;

    localparam logic [1:0] c_DIR_CENTRE = 2'b00;
    localparam logic [1:0] c_DIR_LEFT   = 2'b01;
    localparam logic [1:0] c_DIR_RIGHT  = 2'b10;

    // Pattern bit 2 is the left sensor; only single-sensor patterns are unambiguous.
    function automatic logic [1:0] next_dir(input logic [2:0] pattern, input logic [1:0] cur);
        case (pattern)
            3'b100:  return c_DIR_LEFT;
            3'b001:  return c_DIR_RIGHT;
            3'b010:  return c_DIR_CENTRE;
            default: return cur;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_debounce.sv
`default_nettype none
// ============================================================================
// Module   : ir_debounce
// Brief    : Two-flop synchronizer, persistence counter and filtered level flop
// Revision : 1.0 - initial release
// ============================================================================
module ir_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_accept
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_mismatch;
    logic               w_accept;

    assign w_mismatch = (r_sync2 != r_level);
    assign w_accept   = w_mismatch && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_level  = r_level;
    assign o_accept = w_accept;

endmodule
`default_nettype wire

// File: rtl/ir_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : ir_sensor_conditioner
// Brief    : Debounces three IR line sensors and tracks line position / loss
// Revision : 1.0 - initial release
// ============================================================================
module ir_sensor_conditioner
    import ir_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int LOST_TIMEOUT    = c_LOST_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ir_sensor1,
    input  logic       ir_sensor2,
    input  logic       ir_sensor3,
    output logic       ir_sensor1_f,
    output logic       ir_sensor2_f,
    output logic       ir_sensor3_f,
    output logic       pattern_chg,
    output logic [1:0] last_dir,
    output logic       line_lost
);

    localparam int                   c_TIMER_W    = $clog2(LOST_TIMEOUT);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(LOST_TIMEOUT - 1);

    logic [2:0]           w_raw;
    logic [2:0]           w_pattern;
    logic [2:0]           w_accept;
    logic                 w_zero;
    state_t               r_state;
    state_t               w_state_next;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_TIMER_W-1:0] w_timer_next;
    logic                 w_line_lost_next;
    logic                 r_line_lost;
    logic                 r_pattern_chg;
    logic [1:0]           r_last_dir;

    // Bit 2 = left (sensor1), bit 0 = right (sensor3).
    assign w_raw = {ir_sensor1, ir_sensor2, ir_sensor3};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_sensor
            ir_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .i_raw   (w_raw[i]),
                .o_level (w_pattern[i]),
                .o_accept(w_accept[i])
            );
        end
    endgenerate

    assign w_zero = (w_pattern == 3'b000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern_chg <= 1'b0;
            r_last_dir    <= c_DIR_CENTRE;
        end else begin
            r_pattern_chg <= |w_accept;
            r_last_dir    <= next_dir(w_pattern, r_last_dir);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SEARCH;
            r_timer     <= '0;
            r_line_lost <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_line_lost <= w_line_lost_next;
        end
    end

    // The timer holds at its last value in LOST so it can never wrap.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        case (r_state)
            ST_ON_LINE: begin
                if (w_zero) begin
                    w_state_next = ST_SEARCH;
                    w_timer_next = '0;
                end
            end
            ST_SEARCH: begin
                if (!w_zero) begin
                    w_state_next = ST_ON_LINE;
                    w_timer_next = '0;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_state_next = ST_LOST;
                end else begin
                    w_timer_next = r_timer + c_TIMER_W'(1);
                end
            end
            ST_LOST: begin
                if (!w_zero) begin
                    w_state_next = ST_ON_LINE;
                    w_timer_next = '0;
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
                w_timer_next = '0;
            end
        endcase
    end

    always_comb begin
        w_line_lost_next = (w_state_next == ST_LOST);
    end

    assign ir_sensor1_f = w_pattern[2];
    assign ir_sensor2_f = w_pattern[1];
    assign ir_sensor3_f = w_pattern[0];
    assign pattern_chg  = r_pattern_chg;
    assign last_dir     = r_last_dir;
    assign line_lost    = r_line_lost;

endmodule
`default_nettype wire

// File: tb/tb_ir_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_sensor_conditioner
// Brief    : Scoreboard bench with a window-based reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_sensor_conditioner;

    localparam int c_D = 4;
    localparam int c_T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    logic       f1, f2, f3, chg, lost;
    logic [1:0] dir;

    always #5 clk = ~clk;

    ir_sensor_conditioner #(
        .DEBOUNCE_CYCLES(c_D),
        .LOST_TIMEOUT   (c_T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ir_sensor1  (s1),
        .ir_sensor2  (s2),
        .ir_sensor3  (s3),
        .ir_sensor1_f(f1),
        .ir_sensor2_f(f2),
        .ir_sensor3_f(f3),
        .pattern_chg (chg),
        .last_dir    (dir),
        .line_lost   (lost)
    );

    typedef struct {int cyc; logic [2:0] pat; logic chg;} pat_ev_t;
    typedef struct {int cyc; logic [1:0] val;} val_ev_t;

    pat_ev_t pat_q[$];
    val_ev_t dir_q[$];
    val_ev_t lost_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: a level is accepted once the last D synchronized samples
    // all disagree with it; LOST follows T+1 consecutive all-zero evaluations
    // (reset counts as one, since it lands directly in SEARCH).
    logic [2:0] m_sync1 = 3'b0, m_sync2 = 3'b0, m_filt = 3'b0;
    logic [2:0] m_hist[$];
    logic [1:0] m_dir = 2'b00;
    logic       m_lost = 1'b0, m_chg = 1'b0;
    int         m_zrun = 1;

    always @(posedge clk) begin
        logic [2:0] old_pat, acc;
        logic [1:0] old_dir;
        logic       old_lost, all_diff;
        cyc++;
        old_pat  = m_filt;
        old_dir  = m_dir;
        old_lost = m_lost;
        if (rst) begin
            m_sync1 = 3'b0;
            m_sync2 = 3'b0;
            m_filt  = 3'b0;
            m_hist.delete();
            m_chg   = 1'b0;
            m_dir   = 2'b00;
            m_zrun  = 1;
            m_lost  = 1'b0;
        end else begin
            m_hist.push_back(m_sync2);
            if (m_hist.size() > c_D) void'(m_hist.pop_front());
            acc = 3'b0;
            if (m_hist.size() == c_D) begin
                for (int i = 0; i < 3; i++) begin
                    all_diff = 1'b1;
                    foreach (m_hist[j]) if (m_hist[j][i] == m_filt[i]) all_diff = 1'b0;
                    acc[i] = all_diff;
                end
            end
            m_filt  = m_filt ^ acc;
            m_chg   = |acc;
            m_sync2 = m_sync1;
            m_sync1 = {s1, s2, s3};
            if (old_pat == 3'b100) m_dir = 2'b01;
            else if (old_pat == 3'b001) m_dir = 2'b10;
            else if (old_pat == 3'b010) m_dir = 2'b00;
            if (old_pat == 3'b000) begin
                if (m_zrun < c_T + 1) m_zrun++;
            end else begin
                m_zrun = 0;
            end
            m_lost = (m_zrun >= c_T + 1);
        end
        if (m_filt != old_pat || m_chg) pat_q.push_back('{cyc, m_filt, m_chg});
        if (m_dir != old_dir) dir_q.push_back('{cyc, m_dir});
        if (m_lost != old_lost) lost_q.push_back('{cyc, {1'b0, m_lost}});
    end

    logic [2:0] mon_pat = 3'b0;
    logic [1:0] mon_dir = 2'b0;
    logic       mon_lost = 1'b0;

    always @(negedge clk) begin
        logic [2:0] pat_now;
        pat_ev_t    pe;
        val_ev_t    ve;
        pat_now = {f1, f2, f3};
        if (chg !== 1'b0 || pat_now !== mon_pat) begin
            n_checks++;
            if (pat_q.size() == 0) begin
                n_errors++;
                $display("FAIL pattern_event cyc=%0d: got pat=%b chg=%b, expected no event", cyc, pat_now, chg);
            end else begin
                pe = pat_q.pop_front();
                if (pe.cyc != cyc || pe.pat !== pat_now || pe.chg !== chg) begin
                    n_errors++;
                    $display("FAIL pattern_event: got cyc=%0d pat=%b chg=%b, expected cyc=%0d pat=%b chg=%b",
                             cyc, pat_now, chg, pe.cyc, pe.pat, pe.chg);
                end
            end
        end
        if (dir !== mon_dir) begin
            n_checks++;
            if (dir_q.size() == 0) begin
                n_errors++;
                $display("FAIL last_dir_event cyc=%0d: got %b, expected no change", cyc, dir);
            end else begin
                ve = dir_q.pop_front();
                if (ve.cyc != cyc || ve.val !== dir) begin
                    n_errors++;
                    $display("FAIL last_dir_event: got cyc=%0d dir=%b, expected cyc=%0d dir=%b", cyc, dir, ve.cyc, ve.val);
                end
            end
        end
        if (lost !== mon_lost) begin
            n_checks++;
            if (lost_q.size() == 0) begin
                n_errors++;
                $display("FAIL line_lost_event cyc=%0d: got %b, expected no change", cyc, lost);
            end else begin
                ve = lost_q.pop_front();
                if (ve.cyc != cyc || ve.val[0] !== lost) begin
                    n_errors++;
                    $display("FAIL line_lost_event: got cyc=%0d lost=%b, expected cyc=%0d lost=%b", cyc, lost, ve.cyc, ve.val[0]);
                end
            end
        end
        mon_pat  = pat_now;
        mon_dir  = dir;
        mon_lost = lost;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int hold;
        logic [2:0] p;
        tick(3);
        check("reset_f",         {1'b0, f1, f2, f3}, 4'h0);
        check("reset_chg",       {3'b0, chg},        4'h0);
        check("reset_dir",       {2'b0, dir},        4'h0);
        check("reset_lost",      {3'b0, lost},       4'h0);
        rst = 1'b0;

        s2 = 1'b1;
        tick(12);
        check("centre_f2",       {3'b0, f2},   4'h1);
        check("centre_dir",      {2'b0, dir},  4'h0);

        s1 = 1'b1;
        tick(3);
        s1 = 1'b0;
        tick(10);
        check("glitch_f1",       {3'b0, f1},   4'h0);

        s1 = 1'b1;
        s3 = 1'b1;
        tick(12);
        check("both_f",          {2'b0, f1, f3}, 4'h3);
        check("both_dir",        {2'b0, dir},    4'h0);

        s1 = 1'b0;
        s3 = 1'b0;
        tick(12);
        s2 = 1'b0;
        tick(6);
        check("search_not_lost", {3'b0, lost}, 4'h0);
        tick(14);
        check("lost_set",        {3'b0, lost}, 4'h1);
        tick(5);
        check("lost_held",       {3'b0, lost}, 4'h1);
        s3 = 1'b1;
        tick(12);
        check("recover_lost",    {3'b0, lost}, 4'h0);
        check("recover_dir",     {2'b0, dir},  4'h2);

        s1 = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        s1  = 1'b0;
        s3  = 1'b0;
        check("midrst_f",        {1'b0, f1, f2, f3}, 4'h0);
        check("midrst_chg",      {3'b0, chg},        4'h0);
        check("midrst_dir",      {2'b0, dir},        4'h0);
        tick(c_T - 1);
        check("midrst_search",   {3'b0, lost}, 4'h0);
        tick(1);
        check("midrst_lost",     {3'b0, lost}, 4'h1);

        for (int it = 0; it < 400; it++) begin
            p = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) p = 3'b000;
            hold = (p == 3'b000 && $urandom_range(0, 2) == 0) ? c_T + 6 : $urandom_range(1, 2 * c_D + 2);
            {s1, s2, s3} = p;
            if ($urandom_range(0, 39) == 0) rst = 1'b1;
            tick(1);
            rst = 1'b0;
            tick(hold);
        end

        {s1, s2, s3} = 3'b000;
        tick(20);
        check("pattern_q_drained", 4'(pat_q.size()),  4'h0);
        check("dir_q_drained",     4'(dir_q.size()),  4'h0);
        check("lost_q_drained",    4'(lost_q.size()), 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
